// File: rtl/video_frame_ddr_sched_pkg.sv
// Shared types and helpers for the video frame DDR burst scheduler.
// Holds the FSM state encoding, the buffer index type and the
// free-buffer selection used when a new input frame begins.
package video_sched_pkg;

    localparam int NUM_BUFS = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef logic [1:0] buf_idx_t;

    // Lowest buffer index that is neither excl_a nor (when excl_b_vld) excl_b.
    // With three buffers and at most two exclusions a free one always exists.
    function automatic buf_idx_t pick_free_buf(
        input buf_idx_t excl_a,
        input buf_idx_t excl_b,
        input logic     excl_b_vld
    );
        buf_idx_t result;
        result = 2'd0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if ((buf_idx_t'(i) != excl_a) &&
                !(excl_b_vld && (buf_idx_t'(i) == excl_b))) begin
                result = buf_idx_t'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/video_frame_ddr_sched_rr_arb.sv
// Two-requester round-robin arbiter (write vs read).
// The last-grant register moves only when a command is accepted, so a
// command held in ISSUE does not disturb the fairness order.
module video_sched_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic req_wr,
    input  logic req_rd,
    input  logic accept,
    input  logic accept_write,
    output logic grant_wr,
    output logic grant_rd
);

    // 1 = the most recently accepted command was a write; reset favours write next.
    logic last_wr;

    // Remember which side was served by the last accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr <= 1'b0;
        end else if (accept) begin
            last_wr <= accept_write;
        end
    end

    // On contention grant the side that was not served last.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (req_wr && req_rd) begin
            grant_wr = !last_wr;
            grant_rd = last_wr;
        end else begin
            grant_wr = req_wr;
            grant_rd = req_rd;
        end
    end

endmodule

// File: rtl/video_frame_ddr_sched.sv
// DDR burst scheduler for a triple-buffered video frame store.
// Issues one 256-bit burst command at a time, alternating fairly between
// the camera write path and the display read path, and rotates the three
// frame buffers so writer and reader never share one.
// Optional feature macro: VIDEO_SCHED_STATS_EN builds the saturating
// stat_drop / stat_repeat counters; without it both read as zero.
module video_frame_ddr_sched
    import video_sched_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int LVL_W        = 8,
    parameter int BURST_LEN    = 16,
    parameter int FRAME_WORDS  = 115200,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_STRIDE = 131072
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic [LVL_W-1:0]  wr_fifo_lvl,
    input  logic [LVL_W-1:0]  rd_fifo_space,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LVL_W-1:0]  cmd_len,
    input  logic              cmd_done,
    output logic [15:0]       stat_drop,
    output logic [15:0]       stat_repeat
);

    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame_words
        $error("FRAME_WORDS must be a multiple of BURST_LEN");
    end
    if ((BURST_LEN <= 0) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_bad_burst_len
        $error("BURST_LEN must be a power of two");
    end

    localparam logic [ADDR_W-1:0] BUF_BASE0  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BUF_BASE1  = ADDR_W'(BASE_ADDR + FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] BUF_BASE2  = ADDR_W'(BASE_ADDR + 2 * FRAME_STRIDE);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

    // Base address per buffer from a constant mux.
    function automatic logic [ADDR_W-1:0] buf_base(input buf_idx_t b);
        case (b)
            2'd0:    return BUF_BASE0;
            2'd1:    return BUF_BASE1;
            default: return BUF_BASE2;
        endcase
    endfunction

    state_t            state;
    buf_idx_t          wr_buf;
    buf_idx_t          rd_buf;
    buf_idx_t          last_done;
    logic              last_done_vld;
    logic              wr_active;
    logic              rd_active;
    logic [ADDR_W-1:0] wr_off;
    logic [ADDR_W-1:0] rd_off;
    logic              pend_wr;
    logic              pend_rd;

    logic              apply;
    logic              wr_elig;
    logic              rd_elig;
    logic              grant_wr;
    logic              grant_rd;
    logic              accept;
    buf_idx_t          rd_buf_next;

    assign cmd_len = LVL_W'(BURST_LEN);
    assign accept  = cmd_valid && cmd_ready;

    // Frame-start bookkeeping, eligibility and the read buffer a
    // simultaneous write start must avoid.
    always_comb begin
        apply       = (state == ST_IDLE) && (pend_wr || pend_rd);
        wr_elig     = wr_active && (32'(wr_fifo_lvl) >= BURST_LEN);
        rd_elig     = rd_active && (32'(rd_fifo_space) >= BURST_LEN);
        rd_buf_next = (pend_rd && last_done_vld) ? last_done : rd_buf;
    end

    video_sched_rr_arb u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_wr       (wr_elig),
        .req_rd       (rd_elig),
        .accept       (accept),
        .accept_write (cmd_write),
        .grant_wr     (grant_wr),
        .grant_rd     (grant_rd)
    );

    // Scheduler FSM: apply frame starts, launch bursts, track offsets and buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cmd_valid     <= 1'b0;
            cmd_write     <= 1'b0;
            cmd_addr      <= '0;
            wr_buf        <= 2'd0;
            rd_buf        <= 2'd2;
            last_done     <= 2'd1;
            last_done_vld <= 1'b0;
            wr_active     <= 1'b0;
            rd_active     <= 1'b0;
            wr_off        <= '0;
            rd_off        <= '0;
            pend_wr       <= 1'b0;
            pend_rd       <= 1'b0;
        end else begin
            // A pulse arriving in the same cycle as an apply stays pending.
            pend_wr <= wr_frame_start || (pend_wr && !apply);
            pend_rd <= rd_frame_start || (pend_rd && !apply);

            case (state)
                ST_IDLE: begin
                    if (apply) begin
                        // Read start first so the write start sees the new rd_buf.
                        if (pend_rd && last_done_vld) begin
                            rd_buf    <= last_done;
                            rd_off    <= '0;
                            rd_active <= 1'b1;
                        end
                        if (pend_wr) begin
                            wr_buf    <= pick_free_buf(rd_buf_next, last_done, last_done_vld);
                            wr_off    <= '0;
                            wr_active <= 1'b1;
                        end
                    end else if (grant_wr || grant_rd) begin
                        cmd_valid <= 1'b1;
                        cmd_write <= grant_wr;
                        cmd_addr  <= grant_wr ? (buf_base(wr_buf) + wr_off)
                                              : (buf_base(rd_buf) + rd_off);
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_WAIT;
                        if (cmd_write) begin
                            wr_off <= wr_off + BURST_STEP;
                            if (wr_off + BURST_STEP == FRAME_END) begin
                                last_done     <= wr_buf;
                                last_done_vld <= 1'b1;
                                wr_active     <= 1'b0;
                            end
                        end else begin
                            rd_off <= rd_off + BURST_STEP;
                            if (rd_off + BURST_STEP == FRAME_END) begin
                                rd_active <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cmd_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VIDEO_SCHED_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] repeat_cnt;
    logic        drop_inc;
    logic        repeat_inc;

    assign drop_inc   = apply && pend_wr && wr_active;
    assign repeat_inc = apply && pend_rd && last_done_vld && (last_done == rd_buf);

    // Saturating counters of abandoned input frames and repeated output frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (drop_inc && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (repeat_inc && (repeat_cnt != 16'hFFFF)) begin
                repeat_cnt <= repeat_cnt + 16'd1;
            end
        end
    end

    assign stat_drop   = drop_cnt;
    assign stat_repeat = repeat_cnt;
`else
    assign stat_drop   = '0;
    assign stat_repeat = '0;
`endif

endmodule
